bit_serial_subtractor: RTL and testbench
========================================

// Module: bit_serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor cell: accepts two WIDTH-bit operands plus a borrow-in over
//  a valid/ready handshake, computes A - B - BI one bit per enabled clock, LSB first, through
//  a single difference/borrow slice with a registered borrow. Complement of the adder logic
//  cell; used where a carry chain is too costly. Sits between operand-producing logic and a
//  result consumer in the AP3 logic-cell primitive library.
// PARAMETERS
//  WIDTH     8   operand/result width in bits; legal range 2..32
// PORTS
//  QCK        in   1      clock; all state updates on rising edge
//  QRT        in   1      reset; synchronous, active-low (QRT=0 at rising QCK resets)
//  QEN        in   1      clock enable; QEN=0 freezes all state and blocks both handshakes
//  A_DATA     in   WIDTH  minuend, sampled on input handshake
//  B_DATA     in   WIDTH  subtrahend, sampled on input handshake
//  BI         in   1      borrow-in, sampled on input handshake
//  IN_VALID   in   1      operands valid
//  IN_READY   out  1      block can accept operands
//  D_DATA     out  WIDTH  difference (A - B - BI) mod 2^WIDTH
//  BO         out  1      borrow-out: 1 iff A < B + BI (unsigned)
//  OUT_VALID  out  1      D_DATA/BO valid
//  OUT_READY  in   1      consumer accepts result
//  BUSY       out  1      1 in RUN state
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. All outputs registered or decoded from state register only.
//  - Reset (QRT=0 at edge): state=IDLE, D_DATA=0, BO=0, OUT_VALID=0, BUSY=0, IN_READY=1,
//    bit counter=0, borrow reg=0, operand shift regs=0. Reset wins over every other event.
//  - Reset mid-RUN or mid-DONE: operation discarded, no OUT_VALID, IN_READY=1 next cycle.
//  - QEN=0: no state, counter, shift or handshake change; outputs hold current values.
//  - IDLE: IN_READY=1. On QEN & IN_VALID: load A/B shift regs, borrow reg<=BI, counter<=0,
//    go RUN (IN_READY=0, BUSY=1 from next cycle).
//  - RUN, each QEN cycle: a=A_sh[0], b=B_sh[0], br=borrow reg;
//    d = a^b^br; br_next = (~a & b) | (~(a^b) & br);
//    result shift reg <= {d, result[WIDTH-1:1]}; A_sh/B_sh shift right; borrow<=br_next;
//    counter++. When counter==WIDTH-1 (last bit): D_DATA<=final result, BO<=br_next,
//    OUT_VALID<=1, BUSY<=0, go DONE.
//  - Latency: OUT_VALID rises exactly WIDTH enabled cycles after the accepting edge.
//  - DONE: OUT_VALID=1, D_DATA/BO stable. On QEN & OUT_READY: OUT_VALID<=0, go IDLE
//    (IN_READY=1 next cycle). No overlap: max throughput one op per WIDTH+2 cycles.
//  - IN_VALID outside IDLE and OUT_READY outside DONE are ignored.
//  - D_DATA/BO retain last result after OUT_VALID falls until next completion or reset.
//  - Counter width $clog2(WIDTH); no wrap past WIDTH-1 (RUN exits there).
// TESTING
//  - WIDTH=8: A=8'h05,B=8'h03,BI=0 -> after 8 cycles OUT_VALID=1, D_DATA=8'h02, BO=0.
//  - A=8'h03,B=8'h05,BI=0 -> D_DATA=8'hFE, BO=1; A=8'h00,B=8'h00,BI=1 -> 8'hFF, BO=1.
//  - A=8'hFF,B=8'hFF,BI=0 -> 8'h00, BO=0; OUT_READY held 0 for 5 cycles -> OUT_VALID,
//    D_DATA stable, IN_READY=0; OUT_READY=1 -> IDLE, IN_READY=1 next cycle.
//  - QEN=0 for 3 cycles mid-RUN -> OUT_VALID at 8+3 cycles after accept, result unchanged.
//  - QRT=0 at bit 4 of RUN -> next cycle IN_READY=1, BUSY=0, OUT_VALID stays 0; new op
//    A=8'h10,B=8'h01 -> D_DATA=8'h0F, BO=0.
//  - Random sweep (1000 ops, random QEN/OUT_READY stalls) vs. reference model A-B-BI.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - BI, one bit per enabled clock, LSB first.
// Single difference/borrow slice with a registered borrow and valid/ready handshakes.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             QEN,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             BI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] D_DATA,
  output logic             BO,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ov_q;
  logic             ir_q;
  logic             busy_q;

  logic             a_b;
  logic             b_b;
  logic             d_b;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    a_b      = a_sh[0];
    b_b      = b_sh[0];
    d_b      = a_b ^ b_b ^ brw;
    br_next  = (~a_b & b_b) | (~(a_b ^ b_b) & brw);
    res_next = {d_b, res[WIDTH-1:1]};
  end

  always_ff @(posedge QCK) begin
    if (!QRT) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
      ir_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (QEN) begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_sh   <= A_DATA;
            b_sh   <= B_DATA;
            brw    <= BI;
            cnt    <= '0;
            ir_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res  <= res_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= br_next;
          cnt  <= cnt + CW'(1);
          // Last bit: publish and park the counter at zero
          if (cnt == LAST) begin
            d_q    <= res_next;
            bo_q   <= br_next;
            ov_q   <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            ov_q  <= 1'b0;
            ir_q  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = ir_q;
  assign D_DATA    = d_q;
  assign BO        = bo_q;
  assign OUT_VALID = ov_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Bench for bit_serial_subtractor: vector table, handshake corners, random sweep.
// Expected results come from plain integer arithmetic on A, B and BI.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         qck = 1'b0;
  logic         qrt;
  logic         qen;
  logic [W-1:0] a_data;
  logic [W-1:0] b_data;
  logic         bi;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_data;
  logic         bo;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .QCK      (qck),
    .QRT      (qrt),
    .QEN      (qen),
    .A_DATA   (a_data),
    .B_DATA   (b_data),
    .BI       (bi),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .D_DATA   (d_data),
    .BO       (bo),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .BUSY     (busy)
  );

  always #5 qck = ~qck;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bi_i, output logic [W-1:0] d,
                                output logic bo_o);
    int diff;
    diff = int'(a) - int'(b) - int'(bi_i);
    bo_o = (diff < 0);
    d    = W'(diff + (1 << W));
  endfunction

  task automatic do_reset();
    @(negedge qck);
    qrt = 1'b0;
    @(posedge qck);
    @(negedge qck);
    qrt = 1'b1;
  endtask

  // One full transaction; gap inserts QEN=0 cycles after 3 enabled RUN cycles
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi_i, input bit rnd, input int gap,
                        input int wait_n, output logic [W-1:0] d,
                        output logic bo_o, output int en_n, output int tot_n);
    int t;
    logic [W-1:0] dh;
    logic boh;
    t = 0;
    en_n = 0;
    tot_n = 0;
    d = '0;
    bo_o = 1'b0;
    while (!in_ready && t < 50) begin
      @(negedge qck);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a_data = a;
    b_data = b;
    bi = bi_i;
    in_valid = 1'b1;
    qen = 1'b1;
    out_ready = 1'b0;
    @(posedge qck);
    @(negedge qck);
    chk("accept_busy_nready", {30'd0, busy, in_ready}, 32'h2);
    while (!out_valid && tot_n < 200) begin
      in_valid = rnd ? 1'($urandom) : 1'b0;
      a_data = W'($urandom);
      b_data = W'($urandom);
      bi = 1'($urandom);
      out_ready = rnd ? 1'($urandom) : 1'b0;
      if (rnd) qen = ($urandom % 4) != 0;
      else qen = !(en_n == 3 && (tot_n - en_n) < gap);
      @(posedge qck);
      tot_n++;
      if (qen) en_n++;
      @(negedge qck);
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    d = d_data;
    bo_o = bo;
    dh = d_data;
    boh = bo;
    for (int i = 0; i < wait_n; i++) begin
      qen = rnd ? (($urandom % 3) != 0) : 1'b1;
      out_ready = qen ? 1'b0 : 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge qck);
      @(negedge qck);
      chk("done_hold", {out_valid, in_ready, bo, d_data},
          {1'b1, 1'b0, boh, dh});
    end
    in_valid = 1'b0;
    qen = 1'b1;
    out_ready = 1'b1;
    @(posedge qck);
    @(negedge qck);
    out_ready = 1'b0;
    chk("release", {out_valid, in_ready, bo, d_data}, {1'b0, 1'b1, boh, dh});
  endtask

  vec_t vecs[8];
  logic [W-1:0] gd, ed;
  logic gbo, ebo;
  int en_n, tot_n;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    qrt = 1'b1;
    qen = 1'b0;
    a_data = 8'hAA;
    b_data = 8'h55;
    bi = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    do_reset();
    chk("reset_state", {in_ready, busy, out_valid, bo, d_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // QEN low blocks the input handshake
    in_valid = 1'b1;
    repeat (2) @(posedge qck);
    @(negedge qck);
    chk("qen_blocks_accept", {in_ready, busy}, 2'b10);
    in_valid = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b0, 0, (i == 3) ? 5 : 0,
             gd, gbo, en_n, tot_n);
      chk($sformatf("vec%0d_d", i), 32'(gd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_bo", i), 32'(gbo), 32'(vecs[i].bo));
      chk($sformatf("vec%0d_lat", i), tot_n, W);
    end

    // Three QEN=0 cycles mid-RUN stretch latency to W+3
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 3, 0, gd, gbo, en_n, tot_n);
    chk("stall_d", 32'(gd), 32'h02);
    chk("stall_bo", 32'(gbo), 32'h0);
    chk("stall_lat", tot_n, W + 3);

    // Reset at bit 4 of RUN discards the operation
    @(negedge qck);
    a_data = 8'h37;
    b_data = 8'h12;
    bi = 1'b0;
    in_valid = 1'b1;
    qen = 1'b1;
    @(posedge qck);
    @(negedge qck);
    in_valid = 1'b0;
    repeat (4) @(posedge qck);
    @(negedge qck);
    qrt = 1'b0;
    @(posedge qck);
    @(negedge qck);
    qrt = 1'b1;
    chk("midrun_reset", {in_ready, busy, out_valid, d_data},
        {1'b1, 1'b0, 1'b0, 8'h00});
    repeat (W + 2) @(posedge qck);
    @(negedge qck);
    chk("midrun_no_valid", {out_valid, in_ready}, 2'b01);
    run_op(8'h10, 8'h01, 1'b0, 1'b0, 0, 0, gd, gbo, en_n, tot_n);
    chk("post_reset_d", 32'(gd), 32'h0F);
    chk("post_reset_bo", 32'(gbo), 32'h0);

    // Random sweep with QEN and OUT_READY stalls
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic rbi;
      ra = W'($urandom);
      rb = W'($urandom);
      rbi = 1'($urandom);
      if (n % 10 == 0) rb = ra;
      model(ra, rb, rbi, ed, ebo);
      run_op(ra, rb, rbi, 1'b1, 0, $urandom_range(0, 3), gd, gbo, en_n,
             tot_n);
      chk("rnd_result", {gbo, gd}, {ebo, ed});
      chk("rnd_en_cycles", en_n, W);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
